// File: rtl/btb_update_ctrl_if.sv
// rtl/btb_update_ctrl_if.sv - EX resolution, flush/redirect and BTB write-slot signals
// master = pipeline/fetch side, slave = update controller.
interface btb_update_ctrl_if;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        flush;
   logic [31:0] redirect_pc;
   logic        btb_req;
   logic        btb_grant;
   logic        btb_force;
   logic        btb_wen;
   logic [1:0]  btb_widx;
   logic [62:0] btb_wentry;

   modport master (
      output ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target, btb_grant,
      input  ex_ready, flush, redirect_pc, btb_req, btb_force, btb_wen, btb_widx, btb_wentry
   );

   modport slave (
      input  ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target, btb_grant,
      output ex_ready, flush, redirect_pc, btb_req, btb_force, btb_wen, btb_widx, btb_wentry
   );
endinterface

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB write sequencer with 2-bit shadow counters and write queue
// Entry layout: [62] valid, [61:60] idx, [59:32] tag, [31:0] target.
module btb_update_ctrl #(
   parameter int         QDEPTH       = 2,
   parameter logic [1:0] CNT_INIT     = 2'b01,
   parameter int         STARVE_LIMIT = 4
) (
   input logic CLK,
   input logic RST,
   btb_update_ctrl_if.slave bus
);
   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {IDLE, REQ} state_t;

   state_t        state_q;
   logic [62:0]   q_mem_q [QDEPTH];
   logic [PW-1:0] wptr_q;
   logic [PW-1:0] rptr_q;
   logic [PW:0]   count_q;
   logic [PW:0]   count_d;

   logic          sh_valid_q [4];
   logic [27:0]   sh_tag_q   [4];
   logic [1:0]    sh_cnt_q   [4];

   logic          flush_q;
   logic [31:0]   redirect_q;
   logic          force_q;
   logic [SW-1:0] starve_q;
   logic [SW-1:0] starve_d;

   logic          q_full;
   logic          accept;
   logic [1:0]    idx;
   logic [27:0]   pc_tag;
   logic          hit;
   logic [1:0]    base;
   logic [1:0]    cnt_new;
   logic          install;
   logic          invalidate;
   logic          push;
   logic [62:0]   push_entry;
   logic          mispredict;
   logic          req;
   logic          pop;

   assign q_full  = (count_q == (PW+1)'(QDEPTH));
   assign accept  = bus.ex_valid & ~q_full;
   assign idx     = bus.ex_pc[3:2];
   assign pc_tag  = bus.ex_pc[31:4];
   assign hit     = sh_valid_q[idx] & (sh_tag_q[idx] == pc_tag);
   assign base    = hit ? sh_cnt_q[idx] : CNT_INIT;

   always_comb begin
      cnt_new = base;
      if (bus.ex_taken) begin
         if (base != 2'b11) cnt_new = base + 2'b01;
      end else if (base != 2'b00) begin
         cnt_new = base - 2'b01;
      end
   end

   // Upper counter bit set means "predict taken": keep or install the entry.
   assign install    = cnt_new[1];
   assign invalidate = ~cnt_new[1] & hit;
   assign push       = accept & (install | invalidate);
   assign push_entry = install ? {1'b1, idx, pc_tag, bus.ex_target}
                               : {1'b0, idx, sh_tag_q[idx], 32'h0};

   assign mispredict = accept & ((bus.ex_taken != bus.ex_pred_taken) |
                       (bus.ex_taken & bus.ex_pred_taken & (bus.ex_target != bus.ex_pred_target)));

   assign req     = (state_q == REQ);
   assign pop     = req & bus.btb_grant;
   assign count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);

   always_comb begin
      starve_d = starve_q;
      if (pop) begin
         starve_d = '0;
      end else if (req && (starve_q != SW'(STARVE_LIMIT))) begin
         starve_d = starve_q + SW'(1);
      end
   end

   assign bus.ex_ready    = ~q_full;
   assign bus.flush       = flush_q;
   assign bus.redirect_pc = redirect_q;
   assign bus.btb_req     = req;
   assign bus.btb_force   = force_q;
   assign bus.btb_wen     = pop;
   assign bus.btb_wentry  = q_mem_q[rptr_q];
   assign bus.btb_widx    = q_mem_q[rptr_q][61:60];

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         flush_q    <= 1'b0;
         redirect_q <= 32'h0;
         force_q    <= 1'b0;
         starve_q   <= '0;
         for (int k = 0; k < 4; k++) begin
            sh_valid_q[k] <= 1'b0;
            sh_tag_q[k]   <= 28'h0;
            sh_cnt_q[k]   <= CNT_INIT;
         end
      end else begin
         count_q <= count_d;
         if (push) begin
            q_mem_q[wptr_q] <= push_entry;
            wptr_q          <= wptr_q + PW'(1);
         end
         if (pop) rptr_q <= rptr_q + PW'(1);

         flush_q <= mispredict;
         if (mispredict) redirect_q <= bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;

         if (accept) begin
            sh_cnt_q[idx] <= cnt_new;
            if (install) begin
               sh_valid_q[idx] <= 1'b1;
               sh_tag_q[idx]   <= pc_tag;
            end else if (hit) begin
               sh_valid_q[idx] <= 1'b0;
            end
         end

         starve_q <= starve_d;
         force_q  <= (starve_d == SW'(STARVE_LIMIT));

         case (state_q)
            IDLE:    if (count_d != '0) state_q <= REQ;
            REQ:     if (count_d == '0) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb/tb_btb_update_ctrl.sv - directed bench with a queue-based reference model
// Model state updates on posedge; all DUT outputs compared on negedge.
module tb_btb_update_ctrl;
   localparam int QD    = 2;
   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   btb_update_ctrl_if bus();

   btb_update_ctrl dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: counters as ints, pending writes as a queue.
   int          m_cnt [4];
   logic [27:0] m_tag [4];
   bit          m_val [4];
   logic [62:0] m_q [$];
   bit          m_flush;
   logic [31:0] m_redir;
   int          m_denied;
   bit          m_force;
   bit          seen_edge = 1'b0;

   bit          w_req, w_ready, w_acc, w_hit, w_mis;
   int          w_base, w_new;
   logic [1:0]  w_i;
   logic [27:0] w_t;

   always @(posedge clk) begin
      seen_edge = 1'b1;
      if (rst) begin
         m_q.delete();
         for (int k = 0; k < 4; k++) begin
            m_cnt[k] = 1;
            m_tag[k] = 28'h0;
            m_val[k] = 1'b0;
         end
         m_flush  = 1'b0;
         m_redir  = 32'h0;
         m_denied = 0;
         m_force  = 1'b0;
      end else begin
         w_req   = (m_q.size() != 0);
         w_ready = (m_q.size() < QD);
         w_acc   = bus.ex_valid && w_ready;
         if (w_req && bus.btb_grant) begin
            void'(m_q.pop_front());
            m_denied = 0;
            m_force  = 1'b0;
         end else if (w_req) begin
            if (m_denied < LIMIT) m_denied++;
            m_force = (m_denied >= LIMIT);
         end
         m_flush = 1'b0;
         if (w_acc) begin
            w_i    = bus.ex_pc[3:2];
            w_t    = bus.ex_pc[31:4];
            w_hit  = m_val[w_i] && (m_tag[w_i] == w_t);
            w_base = w_hit ? m_cnt[w_i] : 1;
            w_new  = bus.ex_taken ? ((w_base < 3) ? w_base + 1 : 3) : ((w_base > 0) ? w_base - 1 : 0);
            if (w_new >= 2) begin
               m_q.push_back({1'b1, w_i, w_t, bus.ex_target});
               m_val[w_i] = 1'b1;
               m_tag[w_i] = w_t;
            end else if (w_hit) begin
               m_q.push_back({1'b0, w_i, m_tag[w_i], 32'h0});
               m_val[w_i] = 1'b0;
            end
            m_cnt[w_i] = w_new;
            w_mis = (bus.ex_taken != bus.ex_pred_taken) ||
                    (bus.ex_taken && bus.ex_pred_taken && (bus.ex_target != bus.ex_pred_target));
            if (w_mis) begin
               m_flush = 1'b1;
               m_redir = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
            end
         end
      end
   end

   bit c_req, c_wen;
   always @(negedge clk) begin
      if (seen_edge) begin
         c_req = (m_q.size() != 0);
         c_wen = c_req && bus.btb_grant;
         chk("flush", 64'(bus.flush), 64'(m_flush));
         if (m_flush) chk("redirect_pc", 64'(bus.redirect_pc), 64'(m_redir));
         chk("ex_ready", 64'(bus.ex_ready), 64'(m_q.size() < QD));
         chk("btb_req", 64'(bus.btb_req), 64'(c_req));
         chk("btb_force", 64'(bus.btb_force), 64'(m_force));
         chk("btb_wen", 64'(bus.btb_wen), 64'(c_wen));
         if (c_wen) begin
            chk("btb_widx", 64'(bus.btb_widx), 64'(m_q[0][61:60]));
            chk("btb_wentry", 64'(bus.btb_wentry), 64'(m_q[0]));
         end
      end
   end

   task automatic drive(input bit v, input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                        input bit pt, input logic [31:0] ptg, input bit gr);
      @(posedge clk);
      #2;
      bus.ex_valid       = v;
      bus.ex_pc          = pc;
      bus.ex_taken       = tk;
      bus.ex_target      = tg;
      bus.ex_pred_taken  = pt;
      bus.ex_pred_target = ptg;
      bus.btb_grant      = gr;
   endtask

   task automatic idle(input bit gr);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, gr);
   endtask

   initial begin
      bus.ex_valid       = 1'b0;
      bus.ex_pc          = 32'h0;
      bus.ex_taken       = 1'b0;
      bus.ex_target      = 32'h0;
      bus.ex_pred_taken  = 1'b0;
      bus.ex_pred_target = 32'h0;
      bus.btb_grant      = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_flush", 64'(bus.flush), 64'd0);
      chk("rst_req", 64'(bus.btb_req), 64'd0);
      chk("rst_ready", 64'(bus.ex_ready), 64'd1);
      chk("rst_model_cnt0", 64'(m_cnt[0]), 64'd1);

      // Install on mispredicted taken branch.
      drive(1, 32'h100, 1, 32'h200, 0, 32'h0, 1);
      idle(1);
      @(negedge clk);
      chk("t1_flush", 64'(bus.flush), 64'd1);
      chk("t1_redirect", 64'(bus.redirect_pc), 64'h200);
      chk("t1_wen", 64'(bus.btb_wen), 64'd1);
      chk("t1_widx", 64'(bus.btb_widx), 64'd0);
      chk("t1_wentry", 64'(bus.btb_wentry), 64'({1'b1, 2'd0, 28'h0000010, 32'h200}));
      chk("t1_model_cnt", 64'(m_cnt[0]), 64'd2);

      // Correct predictions: counter saturates, writes still queued.
      drive(1, 32'h100, 1, 32'h200, 1, 32'h200, 1);
      drive(1, 32'h100, 1, 32'h200, 1, 32'h200, 1);
      @(negedge clk);
      chk("t3_noflush_a", 64'(bus.flush), 64'd0);
      idle(1);
      @(negedge clk);
      chk("t3_noflush_b", 64'(bus.flush), 64'd0);
      chk("t3_model_cnt", 64'(m_cnt[0]), 64'd3);

      // Back-to-back not-taken mispredicts: 3->2 rewrite, 2->1 invalidate.
      drive(1, 32'h100, 0, 32'h200, 1, 32'h200, 1);
      drive(1, 32'h100, 0, 32'h200, 1, 32'h200, 1);
      @(negedge clk);
      chk("t2_flush_a", 64'(bus.flush), 64'd1);
      chk("t2_redir_a", 64'(bus.redirect_pc), 64'h104);
      chk("t2_cnt_a", 64'(m_cnt[0]), 64'd2);
      idle(1);
      @(negedge clk);
      chk("t2_flush_b", 64'(bus.flush), 64'd1);
      chk("t2_redir_b", 64'(bus.redirect_pc), 64'h104);
      chk("t2_cnt_b", 64'(m_cnt[0]), 64'd1);
      repeat (3) idle(1);

      // Starvation with a full queue; a branch offered while full is not accepted.
      drive(1, 32'h208, 1, 32'h300, 0, 32'h0, 0);
      drive(1, 32'h20C, 1, 32'h300, 0, 32'h0, 0);
      drive(1, 32'h300, 1, 32'h400, 0, 32'h0, 0);
      @(negedge clk);
      chk("t4_ready_full", 64'(bus.ex_ready), 64'd0);
      idle(0);
      @(negedge clk);
      chk("t4_no_accept_flush", 64'(bus.flush), 64'd0);
      repeat (5) idle(0);
      @(negedge clk);
      chk("t4_force", 64'(bus.btb_force), 64'd1);
      idle(1);
      @(negedge clk);
      chk("t4_head0", 64'(bus.btb_wentry), 64'({1'b1, 2'd2, 28'h0000020, 32'h300}));
      idle(1);
      @(negedge clk);
      chk("t4_head1", 64'(bus.btb_wentry), 64'({1'b1, 2'd3, 28'h0000020, 32'h300}));
      chk("t4_force_clr", 64'(bus.btb_force), 64'd0);
      repeat (2) idle(1);

      // Aliasing on index 1.
      drive(1, 32'h104, 1, 32'h500, 0, 32'h0, 1);
      drive(1, 32'h144, 0, 32'h0, 0, 32'h0, 1);
      idle(1);
      @(negedge clk);
      chk("t5_noflush", 64'(bus.flush), 64'd0);
      chk("t5_cnt", 64'(m_cnt[1]), 64'd0);
      chk("t5_tag", 64'(m_tag[1]), 64'h10);
      chk("t5_val", 64'(m_val[1]), 64'd1);
      drive(1, 32'h104, 1, 32'h500, 1, 32'h500, 1);
      idle(1);
      @(negedge clk);
      chk("t5_inv_wen", 64'(bus.btb_wen), 64'd1);
      chk("t5_inv_entry", 64'(bus.btb_wentry), 64'({1'b0, 2'd1, 28'h0000010, 32'h0}));
      repeat (2) idle(1);

      // Reset with two queued writes.
      drive(1, 32'h208, 0, 32'h0, 1, 32'h300, 0);
      drive(1, 32'h20C, 0, 32'h0, 1, 32'h300, 0);
      idle(0);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_req_before", 64'(bus.btb_req), 64'd1);
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("t6_req", 64'(bus.btb_req), 64'd0);
      chk("t6_flush", 64'(bus.flush), 64'd0);
      chk("t6_ready", 64'(bus.ex_ready), 64'd1);
      chk("t6_cnt2", 64'(m_cnt[2]), 64'd1);

      // Mixed vectors, grant toggling, model-checked.
      drive(1, 32'h0000_1008, 1, 32'h0000_2000, 0, 32'h0, 0);
      drive(1, 32'h0000_1008, 1, 32'h0000_2004, 1, 32'h0000_2000, 1);
      drive(1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h8, 0);
      drive(1, 32'hFFFF_FFFC, 1, 32'h10, 0, 32'h0, 1);
      drive(1, 32'h0000_1008, 0, 32'h0, 1, 32'h2004, 0);
      drive(1, 32'h0000_1008, 0, 32'h0, 0, 32'h0, 1);
      drive(1, 32'h0000_3004, 1, 32'h40, 1, 32'h40, 1);
      @(negedge clk);
      repeat (4) idle(1);
      @(negedge clk);
      chk("wrap_redirect_seen", 64'(m_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
Sequences all writes into the branch target buffer from EX-stage branch resolution. Keeps a per-index 2-bit saturating counter with a shadow tag and decides whether each outcome installs, invalidates or leaves a BTB entry. Queues those writes and shares the single BTB write slot with fetch-side lookups, with anti-starvation forcing. Also produces the registered mispredict flush/redirect for the PC block.

Parameters:
QDEPTH, 2, write-queue depth (entries); 2 only, power of two.
CNT_INIT, 2'b01, counter value after reset or tag replacement (weakly not-taken).
STARVE_LIMIT, 4, consecutive denied-request cycles before btb_force asserts.

Ports:
CLK  input  1  system clock, all state on rising edge.
RST  input  1  synchronous, active-high reset.
ex_valid  input  1  resolved branch present in EX.
ex_ready  output  1  controller can accept; ~queue_full (combinational).
ex_pc  input  32  branch instruction PC (word_t).
ex_taken  input  1  actual outcome.
ex_target  input  32  actual taken target.
ex_pred_taken  input  1  prediction carried down pipeline (btb_hit at fetch).
ex_pred_target  input  32  predicted PC carried down pipeline.
flush  output  1  registered mispredict pulse.
redirect_pc  output  32  correct next PC, valid while flush=1.
btb_req  output  1  controller wants the BTB write slot.
btb_grant  input  1  slot granted this cycle (fetch arbiter).
btb_force  output  1  starvation; fetch arbiter must grant next cycle.
btb_wen  output  1  write strobe = btb_req & btb_grant.
btb_widx  output  2  entry index = pc[3:2].
btb_wentry  output  63  branchentry_t {valid, idx, tag=pc[31:4], value}.

Behaviour:
- Reset (RST=1 at edge): queue empty, FSM IDLE, starve count 0; all 4 shadow entries valid=0, tag=0, cnt=CNT_INIT. flush=0, redirect_pc=0, btb_req=0, btb_force=0, btb_wen=0. Reset mid-write drops queued writes; no partial write.
- Accept = ex_valid & ex_ready. No accept -> no state change, no flush; EX stalls.
- Mispredict = accept & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_target)).
- Next cycle: flush=1 for exactly one cycle; redirect_pc = ex_taken ? ex_target : ex_pc+4 (32-bit wrap).
- Back-to-back mispredicts give back-to-back flush pulses.
- Counter, index i = ex_pc[3:2], on accept:
  - Shadow hit = shadow[i].valid & shadow[i].tag == ex_pc[31:4]. On miss, base = CNT_INIT, else shadow cnt.
  - new = taken ? min(base+1,3) : max(base-1,0).
  - Shadow updated at the edge; the next cycle sees the new value for the same index.
- Write decision:
  - new>=2: enqueue {1,i,pc[31:4],ex_target}; shadow valid=1, tag set.
  - new<2 and hit: enqueue {0,i,tag,0}; shadow valid=0, cnt keeps new value.
  - new<2 and miss: no enqueue; shadow tag/valid unchanged.
- Queue: FIFO of QDEPTH; order preserved, no coalescing. Push and pop in the same cycle are legal at any count.
- FSM:
  - IDLE: btb_req=0; go to REQ when the queue is non-empty at an edge.
  - REQ: btb_req=1 and head drives btb_widx/btb_wentry. On btb_grant, btb_wen=1 and head pops. Return to IDLE if the queue is then empty, else stay in REQ.
- Starvation: count cycles in REQ with btb_grant=0. At STARVE_LIMIT, btb_force=1 (registered); cleared the cycle after a grant. Count resets on grant.
- btb_wen is never 1 with btb_req=0. The entry is written in full, with no read-modify-write against the BTB.

Test Plan:
- Reset, then ex_pc=0x100 taken to 0x200, pred_taken=0 -> next cycle flush=1, redirect_pc=0x200; cnt[0]=2; btb_req=1; with grant btb_wen=1, widx=0, wentry={1,0,0x0000010,0x200}.
- Same PC not-taken twice with pred_taken=1 target 0x200 -> flush with redirect 0x104 on both; 1st: cnt 3->2, no invalidate (new>=2, rewrite valid); 2nd: 2->1 -> invalidate write valid=0.
- Correct prediction (taken, targets equal) -> no flush; counter saturates at 3, write still queued.
- Hold btb_grant=0 with 2 queued -> ex_ready=0 and btb_force=1 after 4 denied cycles; grant -> pop in order, force clears.
- Aliasing: 0x104 then 0x144 (same idx 1, new tag) not-taken -> cnt reset to CNT_INIT then 0, no write; shadow tag unchanged.
- RST asserted with 2 queued and btb_req=1 -> next cycle btb_req=0, queue empty, counters=01, flush=0.
